// File: rtl/mips_int_ctrl.sv
// Edge-latched, maskable, fixed-priority interrupt controller for the multicycle MIPS core.
// Define MIPS_INT_SYNC_EN to put a two-flop synchroniser in front of edge detection.
module mips_int_ctrl #(
    parameter int          NUM_IRQ       = 8,
    parameter int          ID_W          = 3,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0180,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_sig,
    output logic [ID_W-1:0]    int_id,
    output logic [31:0]        int_vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic               in_service
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] req, clr, rise;
    logic [ID_W-1:0]    id_q, id_d, win_id;
    logic               sig_q, sig_d;
    logic               svc_q, svc_d;
    logic [31:0]        vec_q, vec_d;

`ifdef MIPS_INT_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    // Handshake: int_sig is a valid that stays high with a frozen int_id/int_vector
    // until the control unit answers with int_ack; int_done closes the service window.
    always_comb begin
        rise       = irq_s & ~irq_prev_q;
        irq_prev_d = irq_s;
        req        = pending_q & mask_q;
        win_id     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) win_id = ID_W'(i);
        end

        state_d = state_q;
        id_d    = id_q;
        sig_d   = sig_q;
        svc_d   = svc_q;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    id_d    = win_id;
                    sig_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    clr     = NUM_IRQ'(1) << id_q;
                    sig_d   = 1'b0;
                    svc_d   = 1'b1;
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (int_done) begin
                    svc_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                sig_d   = 1'b0;
                svc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A new edge on the same cycle as the acknowledge must not be lost.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
        vec_d     = VECTOR_BASE + 32'(id_d) * VECTOR_STRIDE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            id_q       <= '0;
            sig_q      <= 1'b0;
            svc_q      <= 1'b0;
            vec_q      <= VECTOR_BASE;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            id_q       <= id_d;
            sig_q      <= sig_d;
            svc_q      <= svc_d;
            vec_q      <= vec_d;
        end
    end

    assign int_sig    = sig_q;
    assign int_id     = id_q;
    assign int_vector = vec_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = svc_q;

endmodule

// File: doc/mips_int_ctrl.md
# mips_int_ctrl

Parametrised interrupt controller for the multicycle MIPS core. It replaces the single raw `int0` line into `control_unit` with NUM_IRQ edge-latched, maskable, fixed-priority sources. It presents one `int_sig` request plus a handler vector and source ID. It holds the request until the control unit acknowledges entry to the handler, then blocks further requests until handler return.

## Interface
Parameters:
- `NUM_IRQ`, 8 — number of interrupt sources, 1..32.
- `ID_W`, 3 — width of `int_id`; must satisfy 2^ID_W ≥ NUM_IRQ.
- `VECTOR_BASE`, 32'h0000_0180 — handler address for source 0.
- `VECTOR_STRIDE`, 32'h0000_0010 — address step between consecutive sources.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_in`  in  NUM_IRQ  raw interrupt sources, rising-edge triggered.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  NUM_IRQ  new mask value; 1 = enabled.
- `int_ack`  in  1  control unit is saving the PC and entering the handler (same cycle as `int_save_pc`).
- `int_done`  in  1  handler return (eret).
- `int_sig`  out  1  interrupt request to `control_unit`.
- `int_id`  out  ID_W  index of the source being requested or serviced.
- `int_vector`  out  32  VECTOR_BASE + int_id × VECTOR_STRIDE, modulo 2^32.
- `pending`  out  NUM_IRQ  latched pending bits, unmasked view.
- `mask`  out  NUM_IRQ  current mask register.
- `in_service`  out  1  handler is active.

## Operation
Reset values:
- `pending` = 0, `mask` = all ones, edge-detect history = 0.
- State = IDLE; `int_sig` = 0, `int_id` = 0, `int_vector` = VECTOR_BASE, `in_service` = 0.

Edge detect:
- `pending[i]` is set on any edge where `irq_in[i]`=1 and the previous sample was 0.
- `pending[i]` is cleared only by `int_ack` for the latched ID.
- If set and clear hit the same bit on the same edge, set wins; the bit stays pending.

Mask:
- `mask_we` loads `mask_wdata` on the edge.
- Masking never clears `pending`; it only hides the bit from arbitration.

Priority: lowest index among `pending & mask` wins.

FSM:
- IDLE: if `pending & mask` ≠ 0, latch the winning ID into `int_id` and go to REQ.
- REQ: `int_sig`=1. `int_id` is frozen, even if the source's bit is later masked. On `int_ack`, clear that pending bit and go to SERVICE.
- SERVICE: `int_sig`=0, `in_service`=1. No nesting. On `int_done`, go to IDLE.
- `int_done` outside SERVICE and `int_ack` outside REQ are ignored.
- `int_ack` and `int_done` together are undefined; the control unit never issues them together.

`rst` in any state returns everything to reset values immediately. In-flight pending bits are lost.

## Timing
- `irq_in[i]` rises and is first sampled high at edge E0: `pending[i]`=1 after E0; `int_sig`=1 with a valid `int_id`/`int_vector` after E1.
- `int_ack` sampled at edge A: `int_sig`=0 and `in_service`=1 after A.
- `int_done` sampled at edge D: back in IDLE after D. If another request is pending, `int_sig`=1 after D+1.
- `int_vector` is a registered function of `int_id` and changes on the same edge as `int_id`.
- `mask_we` at edge M affects arbitration from edge M+1 onward.

## Configuration
- `MIPS_INT_SYNC_EN` defined: each `irq_in` bit passes through a two-flop synchroniser before edge detect. Latency irq→`int_sig` becomes 4 edges (E0+3); synchroniser flops reset to 0.
- `MIPS_INT_SYNC_EN` undefined: `irq_in` is sampled directly. It must be synchronous to `clk`.

## Test plan
- Reset then single source: pulse `irq_in[3]` high for 1 cycle → `pending`=8'h08 after E0; `int_sig`=1, `int_id`=3, `int_vector`=32'h1B0 after E1; `int_ack` → `pending`=0, `in_service`=1.
- Priority: `irq_in` 0→8'h24 on one edge → `int_id`=2 first. After ack+done, `int_sig` rises again with `int_id`=5.
- Mask: `mask`=8'hFE, pulse `irq_in[0]` → `pending`=8'h01, `int_sig` stays 0. Writing `mask`=8'hFF → `int_sig`=1, `int_id`=0 one edge later.
- Set/clear collision: new `irq_in[1]` rising edge on the same edge as `int_ack` for ID 1 → `pending[1]` remains 1. After `int_done`, ID 1 is requested again.
- No nesting and level hold: in SERVICE, pulse `irq_in[0]` → `int_sig` stays 0 until `int_done`. Holding `irq_in[4]` high continuously produces only one pending event.
- Mid-operation reset: assert `rst` in REQ and in SERVICE → all outputs at reset values after the edge. With `MIPS_INT_SYNC_EN`, the E0-to-`int_sig` latency is verified as 3 edges.
